alu8_reg: RTL and testbench

- Parameterised integer ALU with registered outputs.
- Two WIDTH-bit operands and a 4-bit opcode produce a WIDTH-bit result and an adder carry flag.
- Sits behind the verification interface bundle (`intf`) and is driven from the shared bench clock (`clk_if`).
- Purely datapath: no handshake, no internal state beyond the output registers.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu8_reg_if.sv | 30 +++
 rtl/alu_comb.sv | 45 ++++
 rtl/alu8_reg.sv | 41 ++++
 tb/tb_alu8_reg.sv | 139 +++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and constants for the registered ALU.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    // Fill bit replicated across the result on a divide by zero (all-ones).
    localparam logic DIV_ZERO_FILL = 1'b1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_SHL  = 4'b0100,
        OP_SHR  = 4'b0101,
        OP_ROL  = 4'b0110,
        OP_ROR  = 4'b0111,
        OP_AND  = 4'b1000,
        OP_OR   = 4'b1001,
        OP_XOR  = 4'b1010,
        OP_NOR  = 4'b1011,
        OP_NAND = 4'b1100,
        OP_XNOR = 4'b1101,
        OP_GT   = 4'b1110,
        OP_EQ   = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/alu8_reg_if.sv
// Operand/opcode/result bundle between the driver and the registered ALU.
interface alu8_reg_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    alu_op_e          ALU_Sel;
    logic [WIDTH-1:0] ALU_Out;
    logic             CarryOut;

    modport master (
        output A,
        output B,
        output ALU_Sel,
        input  ALU_Out,
        input  CarryOut
    );

    modport slave (
        input  A,
        input  B,
        input  ALU_Sel,
        output ALU_Out,
        output CarryOut
    );

endinterface

// File: rtl/alu_comb.sv
// Combinational opcode decode and compute; carry always comes from A+B.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_e          i_sel,
    output logic [WIDTH-1:0] o_result_c,
    output logic             o_carry_c
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [SUM_W-1:0] w_sum;

    assign w_sum     = SUM_W'(i_a) + SUM_W'(i_b);
    assign o_carry_c = w_sum[WIDTH];

    // Result select; every opcode is defined so the default is never held.
    always_comb begin
        o_result_c = '0;
        case (i_sel)
            OP_ADD:  o_result_c = w_sum[WIDTH-1:0];
            OP_SUB:  o_result_c = i_a - i_b;
            OP_MUL:  o_result_c = WIDTH'(i_a * i_b);
            OP_DIV:  o_result_c = (i_b == '0) ? {WIDTH{DIV_ZERO_FILL}} : (i_a / i_b);
            OP_SHL:  o_result_c = {i_a[WIDTH-2:0], 1'b0};
            OP_SHR:  o_result_c = {1'b0, i_a[WIDTH-1:1]};
            OP_ROL:  o_result_c = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
            OP_ROR:  o_result_c = {i_a[0], i_a[WIDTH-1:1]};
            OP_AND:  o_result_c = i_a & i_b;
            OP_OR:   o_result_c = i_a | i_b;
            OP_XOR:  o_result_c = i_a ^ i_b;
            OP_NOR:  o_result_c = ~(i_a | i_b);
            OP_NAND: o_result_c = ~(i_a & i_b);
            OP_XNOR: o_result_c = ~(i_a ^ i_b);
            OP_GT:   o_result_c = WIDTH'(i_a > i_b);
            OP_EQ:   o_result_c = WIDTH'(i_a == i_b);
            default: o_result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu8_reg.sv
// Parameterised ALU with a single output register stage and synchronous reset.
module alu8_reg
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    alu8_reg_if.slave  intf
);

    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .i_a        (intf.A),
        .i_b        (intf.B),
        .i_sel      (intf.ALU_Sel),
        .o_result_c (w_result),
        .o_carry_c  (w_carry)
    );

    // Output stage: reset wins over whatever the ALU computes this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_out   <= w_result;
            r_carry <= w_carry;
        end
    end

    assign intf.ALU_Out  = r_out;
    assign intf.CarryOut = r_carry;

endmodule

// File: tb/tb_alu8_reg.sv
// Scoreboard bench for alu8_reg: expected {carry,result} queued at drive, popped after the edge.
module tb_alu8_reg;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic clk;
    logic reset;

    alu8_reg_if #(.WIDTH(WIDTH)) intf ();

    alu8_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .intf  (intf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec;
    int n_err;
    logic [8:0] exp_q[$];

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Integer reference model, written arithmetically rather than bitwise.
    function automatic logic [8:0] model(input logic rst, input int a, input int b, input int sel);
        int r;
        int c;
        if (rst) return 9'h000;
        c = ((a + b) > 255) ? 1 : 0;
        case (sel)
            0:  r = (a + b) % 256;
            1:  r = (a - b + 256) % 256;
            2:  r = (a * b) % 256;
            3:  r = (b == 0) ? 255 : a / b;
            4:  r = (a * 2) % 256;
            5:  r = a / 2;
            6:  r = (a * 2) % 256 + a / 128;
            7:  r = a / 2 + (a % 2) * 128;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a | b);
            12: r = 255 - (a & b);
            13: r = 255 - (a ^ b);
            14: r = (a > b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        return {c[0], r[7:0]};
    endfunction

    // Drive one vector away from the edge, queue its expectation, check after the edge.
    task automatic apply(input logic rst, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, input string tag);
        logic [8:0] exp;
        reset        = rst;
        intf.A       = a;
        intf.B       = b;
        intf.ALU_Sel = alu_op_e'(sel);
        exp_q.push_back(model(rst, int'(a), int'(b), int'(sel)));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 16'd0, 16'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_out"},   16'(intf.ALU_Out),  16'(exp[7:0]));
            check({tag, "_carry"}, 16'(intf.CarryOut), 16'(exp[8]));
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        intf.A       = 8'h00;
        intf.B       = 8'h00;
        intf.ALU_Sel = OP_ADD;

        // Reset held two cycles with live operands, then released.
        apply(1'b1, 8'h55, 8'hAA, 4'b0000, "rst0");
        apply(1'b1, 8'h55, 8'hAA, 4'b0000, "rst1");
        apply(1'b0, 8'h55, 8'hAA, 4'b0000, "rst_release");
        check("rst_release_lit", 16'(intf.ALU_Out), 16'h00FF);

        // Add with carry, then plain add; repeat to confirm the outputs hold.
        apply(1'b0, 8'hFF, 8'h01, 4'b0000, "add_ovf");
        check("add_ovf_carry_lit", 16'(intf.CarryOut), 16'h0001);
        apply(1'b0, 8'h10, 8'h20, 4'b0000, "add");
        apply(1'b0, 8'h10, 8'h20, 4'b0000, "add_hold");

        apply(1'b0, 8'h00, 8'h01, 4'b0001, "sub_under");
        apply(1'b0, 8'h10, 8'h11, 4'b0010, "mul");
        apply(1'b0, 8'h64, 8'h07, 4'b0011, "div");
        apply(1'b0, 8'h64, 8'h00, 4'b0011, "div0");
        check("div0_lit", 16'(intf.ALU_Out), 16'h00FF);

        for (int s = 4; s < 8; s++)
            apply(1'b0, 8'h81, 8'h00, 4'(s), $sformatf("shrot%0d", s));

        for (int s = 8; s < 16; s++)
            apply(1'b0, 8'hF0, 8'h3C, 4'(s), $sformatf("logic%0d", s));
        apply(1'b0, 8'h3C, 8'h3C, 4'b1111, "eq_true");
        check("eq_true_lit", 16'(intf.ALU_Out), 16'h0001);

        // Back-to-back opcodes with a reset dropped in mid-sequence.
        for (int s = 0; s < 16; s++) begin
            if (s == 9)
                apply(1'b1, 8'hA7, 8'h5C, 4'(s), "b2b_rst");
            apply(1'b0, 8'hA7, 8'h5C, 4'(s), $sformatf("b2b%0d", s));
        end

        // Random mix, including occasional zero divisor and equal operands.
        for (int i = 0; i < 48; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = (i % 7 == 0) ? 8'h00 : ((i % 11 == 0) ? ra : 8'($urandom_range(0, 255)));
            apply(1'b0, ra, rb, 4'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
        end

        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
